// File: rtl/regf_wb_arbiter_if.sv
// Write-back bus between execute/memory units, issue/decode and the regfile write port.
// Latency: n/a (signal bundle only).
// Backpressure: req_ready is the only flow-control signal; a result is taken on req_valid & req_ready.
// Ports: req_valid/req_ready/req_rd/req_data (write-back requesters), claim_valid/claim_rd (issue),
//        addr_rs1/addr_rs2 -> rs1_busy/rs2_busy (decode), write_regf_en/addr_rd/rd_value (regfile).
interface regf_wb_arbiter_if #(
  parameter int NREQ = 3,
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*AW-1:0]   req_rd;
  logic [NREQ*XLEN-1:0] req_data;
  logic                 claim_valid;
  logic [AW-1:0]        claim_rd;
  logic [AW-1:0]        addr_rs1;
  logic [AW-1:0]        addr_rs2;
  logic                 rs1_busy;
  logic                 rs2_busy;
  logic                 write_regf_en;
  logic [AW-1:0]        addr_rd;
  logic [XLEN-1:0]      rd_value;

  // Producer side: requesters, issue and decode stages.
  modport master (
    output req_valid, req_rd, req_data, claim_valid, claim_rd, addr_rs1, addr_rs2,
    input  req_ready, rs1_busy, rs2_busy, write_regf_en, addr_rd, rd_value
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_rd, req_data, claim_valid, claim_rd, addr_rs1, addr_rs2,
    output req_ready, rs1_busy, rs2_busy, write_regf_en, addr_rd, rd_value
  );
endinterface

// File: rtl/regf_wb_arbiter.sv
// Round-robin arbiter for the single regfile write port plus a per-register busy scoreboard.
// Latency: 1 cycle from accept to write_regf_en/addr_rd/rd_value; grant and hazard query are combinational.
// Backpressure: one requester accepted per cycle via one-hot req_ready; losers hold req_valid and wait.
// Ports: clk, rst (async active-low), bus (regf_wb_arbiter_if.slave) carrying requester, claim,
//        hazard-query and regfile write signals.
module regf_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input logic               clk,
  input logic               rst,
  regf_wb_arbiter_if.slave  bus
);

  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int NREG = 1 << AW;

  logic [PW-1:0]   ptr;
  logic [PW-1:0]   gnt_idx;
  logic [PW-1:0]   cand;
  logic [NREQ-1:0] gnt;
  logic            accept;
  logic [AW-1:0]   sel_rd;
  logic [XLEN-1:0] sel_data;

  logic            wen_q;
  logic [AW-1:0]   addr_q;
  logic [XLEN-1:0] data_q;

  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;

  // Search starts just after the last winner, so the last winner has lowest priority.
  // Only req_valid feeds the grant; rd/data never influence req_ready.
  always_comb begin
    gnt     = '0;
    gnt_idx = ptr;
    accept  = 1'b0;
    cand    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = PW'((int'(ptr) + k) % NREQ);
      if (!accept && bus.req_valid[cand]) begin
        accept    = 1'b1;
        gnt[cand] = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_rd   = bus.req_rd[i*AW +: AW];
        sel_data = bus.req_data[i*XLEN +: XLEN];
      end
    end
  end

  // Clear is applied before set so a claim landing on the same edge as the
  // write-back of an older producer leaves the register busy.
  always_comb begin
    busy_nxt = busy;
    if (accept) begin
      busy_nxt[sel_rd] = 1'b0;
    end
    if (bus.claim_valid && (bus.claim_rd != '0)) begin
      busy_nxt[bus.claim_rd] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr    <= PW'(NREQ - 1);
      wen_q  <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      busy   <= '0;
    end else begin
      busy <= busy_nxt;
      if (accept) begin
        ptr    <= gnt_idx;
        wen_q  <= (sel_rd != '0);
        addr_q <= sel_rd;
        data_q <= sel_data;
      end else begin
        wen_q <= 1'b0;
      end
    end
  end

  assign bus.req_ready     = gnt;
  assign bus.write_regf_en = wen_q;
  assign bus.addr_rd       = addr_q;
  assign bus.rd_value      = data_q;

  // The output-stage term covers a value that has left the scoreboard but is
  // not yet visible in the regfile.
  assign bus.rs1_busy = (bus.addr_rs1 != '0) &&
                        (busy[bus.addr_rs1] || (wen_q && (addr_q == bus.addr_rs1)));
  assign bus.rs2_busy = (bus.addr_rs2 != '0) &&
                        (busy[bus.addr_rs2] || (wen_q && (addr_q == bus.addr_rs2)));

endmodule

// File: tb/tb_regf_wb_arbiter.sv
// Self-checking bench for regf_wb_arbiter: expected regfile writes are queued when a grant is
// expected and popped one edge later against write_regf_en/addr_rd/rd_value.
module tb_regf_wb_arbiter;
  localparam int NREQ = 3;
  localparam int XLEN = 32;
  localparam int AW   = 5;

  typedef struct packed {
    logic            en;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regf_wb_arbiter_if #(.NREQ(NREQ), .XLEN(XLEN), .AW(AW)) bus ();

  regf_wb_arbiter #(.NREQ(NREQ), .XLEN(XLEN), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  wr_t exp_q[$];
  wr_t e;
  int  total = 0;
  int  bad   = 0;

  task automatic set_req(input int i, input logic v, input logic [AW-1:0] rd, input logic [XLEN-1:0] d);
    bus.req_valid[i]              = v;
    bus.req_rd[i*AW +: AW]        = rd;
    bus.req_data[i*XLEN +: XLEN]  = d;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, AW'(i + 1), XLEN'(32'hA000_0000 + i));
    repeat (2) tick;
    total++;
    if ({bus.write_regf_en, bus.addr_rd, bus.rd_value} !== {1'b0, {AW{1'b0}}, {XLEN{1'b0}}}) begin
      bad++;
      $display("FAIL reset_out: got en/rd/val=%h expected 0", {bus.write_regf_en, bus.addr_rd, bus.rd_value});
    end
    for (int a = 1; a < (1 << AW); a++) begin
      bus.addr_rs1 = AW'(a);
      #1;
      total++;
      if (bus.rs1_busy !== 1'b0) begin
        bad++;
        $display("FAIL reset_busy: addr=%0d got %b expected 0", a, bus.rs1_busy);
      end
    end
    tick;
    rst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      int g = k % NREQ;
      #1;
      total++;
      if (bus.req_ready !== NREQ'(1 << g)) begin
        bad++;
        $display("FAIL rr_grant: step %0d got %b expected %b", k, bus.req_ready, NREQ'(1 << g));
      end
      exp_q.push_back(wr_t'{en: 1'b1, rd: AW'(g + 1), data: XLEN'(32'hA000_0000 + g)});
      tick;
      e = exp_q.pop_front();
      total++;
      if ({bus.write_regf_en, bus.addr_rd, bus.rd_value} !== e) begin
        bad++;
        $display("FAIL rr_write: step %0d got %h expected %h", k, {bus.write_regf_en, bus.addr_rd, bus.rd_value}, e);
      end
    end
    bus.req_valid = '0;
    tick;
    total++;
    if (bus.write_regf_en !== 1'b0) begin
      bad++;
      $display("FAIL rr_idle: got en=%b expected 0", bus.write_regf_en);
    end
  endtask

  task automatic test_single;
    set_req(0, 1'b1, AW'(5), 32'hDEAD_BEEF);
    #1;
    total++;
    if (bus.req_ready !== 3'b001) begin
      bad++;
      $display("FAIL single_grant: got %b expected 001", bus.req_ready);
    end
    exp_q.push_back(wr_t'{en: 1'b1, rd: AW'(5), data: 32'hDEAD_BEEF});
    tick;
    set_req(0, 1'b0, '0, '0);
    e = exp_q.pop_front();
    total++;
    if ({bus.write_regf_en, bus.addr_rd, bus.rd_value} !== e) begin
      bad++;
      $display("FAIL single_write: got %h expected %h", {bus.write_regf_en, bus.addr_rd, bus.rd_value}, e);
    end
    tick;
    total++;
    if ({bus.write_regf_en, bus.addr_rd, bus.rd_value} !== {1'b0, AW'(5), 32'hDEAD_BEEF}) begin
      bad++;
      $display("FAIL single_idle: got %h expected en=0 rd=5 val held", {bus.write_regf_en, bus.addr_rd, bus.rd_value});
    end
  endtask

  task automatic test_claim;
    bus.claim_valid = 1'b1;
    bus.claim_rd    = AW'(7);
    bus.addr_rs1    = AW'(7);
    tick;
    bus.claim_valid = 1'b0;
    #1;
    total++;
    if (bus.rs1_busy !== 1'b1) begin
      bad++;
      $display("FAIL claim_busy: got %b expected 1", bus.rs1_busy);
    end
    tick;
    total++;
    if (bus.rs1_busy !== 1'b1) begin
      bad++;
      $display("FAIL claim_hold: got %b expected 1", bus.rs1_busy);
    end
    set_req(2, 1'b1, AW'(7), 32'h0000_0777);
    #1;
    total++;
    if (bus.req_ready !== 3'b100) begin
      bad++;
      $display("FAIL claim_grant: got %b expected 100", bus.req_ready);
    end
    exp_q.push_back(wr_t'{en: 1'b1, rd: AW'(7), data: 32'h0000_0777});
    tick;
    set_req(2, 1'b0, '0, '0);
    e = exp_q.pop_front();
    total++;
    if ({bus.write_regf_en, bus.addr_rd, bus.rd_value} !== e) begin
      bad++;
      $display("FAIL claim_write: got %h expected %h", {bus.write_regf_en, bus.addr_rd, bus.rd_value}, e);
    end
    total++;
    if (bus.rs1_busy !== 1'b1) begin
      bad++;
      $display("FAIL claim_outstage: got %b expected 1", bus.rs1_busy);
    end
    tick;
    total++;
    if (bus.rs1_busy !== 1'b0) begin
      bad++;
      $display("FAIL claim_release: got %b expected 0", bus.rs1_busy);
    end
  endtask

  task automatic test_same_edge;
    bus.claim_valid = 1'b1;
    bus.claim_rd    = AW'(9);
    bus.addr_rs2    = AW'(9);
    set_req(1, 1'b1, AW'(9), 32'h0000_0099);
    #1;
    total++;
    if (bus.req_ready !== 3'b010) begin
      bad++;
      $display("FAIL same_grant: got %b expected 010", bus.req_ready);
    end
    exp_q.push_back(wr_t'{en: 1'b1, rd: AW'(9), data: 32'h0000_0099});
    tick;
    bus.claim_valid = 1'b0;
    set_req(1, 1'b0, '0, '0);
    e = exp_q.pop_front();
    total++;
    if ({bus.write_regf_en, bus.addr_rd, bus.rd_value} !== e) begin
      bad++;
      $display("FAIL same_write: got %h expected %h", {bus.write_regf_en, bus.addr_rd, bus.rd_value}, e);
    end
    tick;
    total++;
    if (bus.rs2_busy !== 1'b1) begin
      bad++;
      $display("FAIL same_busy_kept: got %b expected 1", bus.rs2_busy);
    end
    set_req(0, 1'b1, AW'(9), 32'h0000_9999);
    #1;
    total++;
    if (bus.req_ready !== 3'b001) begin
      bad++;
      $display("FAIL same_clear_grant: got %b expected 001", bus.req_ready);
    end
    exp_q.push_back(wr_t'{en: 1'b1, rd: AW'(9), data: 32'h0000_9999});
    tick;
    set_req(0, 1'b0, '0, '0);
    e = exp_q.pop_front();
    total++;
    if ({bus.write_regf_en, bus.addr_rd, bus.rd_value} !== e) begin
      bad++;
      $display("FAIL same_clear_write: got %h expected %h", {bus.write_regf_en, bus.addr_rd, bus.rd_value}, e);
    end
    tick;
    total++;
    if (bus.rs2_busy !== 1'b0) begin
      bad++;
      $display("FAIL same_cleared: got %b expected 0", bus.rs2_busy);
    end
  endtask

  task automatic test_rd_zero;
    set_req(0, 1'b1, AW'(4), 32'h0000_0044);
    set_req(1, 1'b1, AW'(0), 32'h0000_1234);
    set_req(2, 1'b1, AW'(3), 32'h0000_0033);
    #1;
    total++;
    if (bus.req_ready !== 3'b010) begin
      bad++;
      $display("FAIL rd0_grant: got %b expected 010", bus.req_ready);
    end
    exp_q.push_back(wr_t'{en: 1'b0, rd: AW'(0), data: 32'h0000_1234});
    tick;
    set_req(1, 1'b0, '0, '0);
    e = exp_q.pop_front();
    total++;
    if ({bus.write_regf_en, bus.addr_rd, bus.rd_value} !== e) begin
      bad++;
      $display("FAIL rd0_write: got %h expected %h", {bus.write_regf_en, bus.addr_rd, bus.rd_value}, e);
    end
    #1;
    total++;
    if (bus.req_ready !== 3'b100) begin
      bad++;
      $display("FAIL rd0_ptr: got %b expected 100", bus.req_ready);
    end
    exp_q.push_back(wr_t'{en: 1'b1, rd: AW'(3), data: 32'h0000_0033});
    tick;
    set_req(0, 1'b0, '0, '0);
    set_req(2, 1'b0, '0, '0);
    e = exp_q.pop_front();
    total++;
    if ({bus.write_regf_en, bus.addr_rd, bus.rd_value} !== e) begin
      bad++;
      $display("FAIL rd0_next: got %h expected %h", {bus.write_regf_en, bus.addr_rd, bus.rd_value}, e);
    end
    tick;
  endtask

  task automatic test_back_to_back;
    for (int k = 0; k < 4; k++) begin
      set_req(0, 1'b1, AW'(10 + k), XLEN'(32'h0000_00B0 + k));
      #1;
      total++;
      if (bus.req_ready !== 3'b001) begin
        bad++;
        $display("FAIL b2b_grant: step %0d got %b expected 001", k, bus.req_ready);
      end
      exp_q.push_back(wr_t'{en: 1'b1, rd: AW'(10 + k), data: XLEN'(32'h0000_00B0 + k)});
      tick;
      e = exp_q.pop_front();
      total++;
      if ({bus.write_regf_en, bus.addr_rd, bus.rd_value} !== e) begin
        bad++;
        $display("FAIL b2b_write: step %0d got %h expected %h", k, {bus.write_regf_en, bus.addr_rd, bus.rd_value}, e);
      end
    end
    set_req(0, 1'b0, '0, '0);
    tick;
    total++;
    if (bus.write_regf_en !== 1'b0) begin
      bad++;
      $display("FAIL b2b_idle: got en=%b expected 0", bus.write_regf_en);
    end
  endtask

  task automatic test_async_reset;
    bus.claim_valid = 1'b1;
    bus.claim_rd    = AW'(12);
    tick;
    bus.claim_rd = AW'(14);
    set_req(1, 1'b1, AW'(13), 32'h0000_1313);
    #1;
    total++;
    if (bus.req_ready !== 3'b010) begin
      bad++;
      $display("FAIL ar_grant: got %b expected 010", bus.req_ready);
    end
    exp_q.push_back(wr_t'{en: 1'b1, rd: AW'(13), data: 32'h0000_1313});
    tick;
    bus.claim_valid = 1'b0;
    set_req(1, 1'b0, '0, '0);
    e = exp_q.pop_front();
    total++;
    if ({bus.write_regf_en, bus.addr_rd, bus.rd_value} !== e) begin
      bad++;
      $display("FAIL ar_pending: got %h expected %h", {bus.write_regf_en, bus.addr_rd, bus.rd_value}, e);
    end
    #2;
    rst = 1'b0;
    #1;
    total++;
    if (bus.write_regf_en !== 1'b0) begin
      bad++;
      $display("FAIL ar_wen: got %b expected 0", bus.write_regf_en);
    end
    for (int a = 1; a < (1 << AW); a++) begin
      bus.addr_rs1 = AW'(a);
      #1;
      total++;
      if (bus.rs1_busy !== 1'b0) begin
        bad++;
        $display("FAIL ar_busy: addr=%0d got %b expected 0", a, bus.rs1_busy);
      end
    end
    tick;
    rst = 1'b1;
    bus.addr_rs1 = AW'(12);
    for (int k = 0; k < 2; k++) begin
      tick;
      total++;
      if ({bus.write_regf_en, bus.rs1_busy} !== 2'b00) begin
        bad++;
        $display("FAIL ar_no_write: cycle %0d got en/busy=%b expected 00", k, {bus.write_regf_en, bus.rs1_busy});
      end
    end
  endtask

  initial begin
    rst             = 1'b0;
    bus.req_valid   = '0;
    bus.req_rd      = '0;
    bus.req_data    = '0;
    bus.claim_valid = 1'b0;
    bus.claim_rd    = '0;
    bus.addr_rs1    = '0;
    bus.addr_rs2    = '0;
    test_reset;
    test_single;
    test_claim;
    test_same_edge;
    test_rd_zero;
    test_back_to_back;
    test_async_reset;
    total++;
    if (exp_q.size() !== 0) begin
      bad++;
      $display("FAIL sb_empty: got %0d entries expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
